// File: rtl/fir_decim_buffer.sv
// rtl/fir_decim_buffer.sv - FIR output decimator (accumulate-and-dump) with small output FIFO
module fir_decim_buffer #(
    parameter int DATA_W     = 8,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               filter_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [$clog2(DECIM)-1:0]        phase,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);
    localparam int PH_W  = $clog2(DECIM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ACC_W = DATA_W + PH_W;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] result;
    logic              blk_done, full, pop, push_ok;

    always_comb begin
        sum      = acc_q + ACC_W'(filter_out);
        result   = sum[ACC_W-1:PH_W];
        blk_done = in_valid && (phase_q == PH_W'(DECIM - 1));
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        pop      = (level_q != '0) && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok  = blk_done && (!full || pop);

        acc_d      = acc_q;
        phase_d    = phase_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q;

        if (clr) begin
            acc_d      = '0;
            phase_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            out_data_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (in_valid) begin
                if (blk_done) begin
                    acc_d   = '0;
                    phase_d = '0;
                end else begin
                    acc_d   = sum;
                    phase_d = phase_q + PH_W'(1);
                end
            end
            if (blk_done && !push_ok)
                overflow_d = 1'b1;
            if (push_ok)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            // Head register tracks the next head; holds last value once empty.
            if (level_d != '0) begin
                if (push_ok && (wr_ptr_q == rd_ptr_d))
                    out_data_d = result;
                else
                    out_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && push_ok)
            mem_q[wr_ptr_q] <= result;
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = out_data_q;
    assign phase      = phase_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_fir_decim_buffer.sv
// tb/tb_fir_decim_buffer.sv - directed self-checking bench for fir_decim_buffer
module tb_fir_decim_buffer;
    logic       clk = 1'b0;
    logic       rst, clr, in_valid, out_ready;
    logic [7:0] filter_out;
    logic       out_valid, overflow;
    logic [7:0] out_data;
    logic [1:0] phase;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

    fir_decim_buffer dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .filter_out(filter_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .phase(phase), .fifo_level(fifo_level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] v);
        filter_out = v;
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    int exp_ramp [6] = '{15, 55, 95, 135, 175, 215};

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; filter_out = '0;
        step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_phase", 32'(phase), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        step();

        // Ramp, consumer always ready: out_valid pulses one cycle per block.
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            filter_out = 8'(i * 10);
            in_valid   = 1'b1;
            step();
            if (i % 4 == 3) begin
                check("ramp_valid", 32'(out_valid), 1);
                check("ramp_data", 32'(out_data), 32'(exp_ramp[i / 4]));
            end else begin
                check("ramp_gap_valid", 32'(out_valid), 0);
            end
        end
        in_valid = 1'b0;
        step();
        check("ramp_ovf", 32'(overflow), 0);
        check("ramp_drained", 32'(out_valid), 0);

        // Full-scale samples must not wrap the accumulator.
        for (int i = 0; i < 8; i++) begin
            feed(8'd255);
            if (i % 4 == 3) check("max_data", 32'(out_data), 255);
        end
        step();

        // Backpressure: fifth result is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) feed(8'(i * 10));
        check("bp_level", 32'(fifo_level), 4);
        check("bp_ovf", 32'(overflow), 1);
        check("bp_phase", 32'(phase), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_drain_valid", 32'(out_valid), 1);
            check("bp_drain_data", 32'(out_data), 32'(exp_ramp[k]));
            step();
        end
        check("bp_empty", 32'(out_valid), 0);
        check("bp_level0", 32'(fifo_level), 0);

        // Full FIFO with a pop on the same edge a block completes.
        pulse_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 19; i++) feed(8'(i * 10));
        check("fp_full", 32'(fifo_level), 4);
        out_ready = 1'b1;
        feed(8'd190);
        out_ready = 1'b0;
        check("fp_level", 32'(fifo_level), 4);
        check("fp_ovf", 32'(overflow), 0);
        check("fp_head", 32'(out_data), 55);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check("fp_drain_data", 32'(out_data), 32'(exp_ramp[k]));
            step();
        end
        check("fp_empty", 32'(out_valid), 0);

        // Gapped input: phase holds across idle cycles.
        out_ready = 1'b0;
        feed(8'd10); step();
        check("gap_phase1", 32'(phase), 1);
        feed(8'd20); step();
        check("gap_phase2", 32'(phase), 2);
        feed(8'd30); step();
        check("gap_nooutput", 32'(out_valid), 0);
        feed(8'd40);
        check("gap_valid", 32'(out_valid), 1);
        check("gap_data", 32'(out_data), 25);
        check("gap_level", 32'(fifo_level), 1);
        out_ready = 1'b1;
        step();
        check("gap_popped", 32'(fifo_level), 0);

        // Async reset mid-block discards the partial accumulation.
        feed(8'd50);
        feed(8'd60);
        rst = 1'b1;
        #1;
        check("arst_phase", 32'(phase), 0);
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed(8'd100);
        check("arst_data", 32'(out_data), 100);
        check("arst_level", 32'(fifo_level), 1);

        // clr beats a simultaneous in_valid and clears overflow.
        for (int i = 0; i < 22; i++) feed(8'd40);
        check("clr_pre_ovf", 32'(overflow), 1);
        clr = 1'b1; in_valid = 1'b1; filter_out = 8'd200;
        step();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_phase", 32'(phase), 0);
        check("clr_level", 32'(fifo_level), 0);
        check("clr_valid", 32'(out_valid), 0);
        check("clr_ovf", 32'(overflow), 0);
        check("clr_data", 32'(out_data), 0);
        for (int i = 0; i < 4; i++) feed(8'd8);
        check("clr_after_data", 32'(out_data), 8);
        check("clr_after_level", 32'(fifo_level), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
